// File: rtl/axis_labcontrol_pkg.sv
// rtl/axis_labcontrol_pkg.sv - shared LabControl setpoint constants and types
package axis_labcontrol_pkg;

  localparam int LC_DATA_WIDTH = 16;
  localparam int LC_TICK_DIV   = 100;

  typedef logic signed [LC_DATA_WIDTH-1:0] lc_setpoint_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RAMP = 1'b1
  } ramp_state_t;

  function automatic int lc_cnt_width(input int div);
    return (div > 1) ? $clog2(div) : 1;
  endfunction

endpackage

// File: rtl/axis_labcontrol_ramp_tick.sv
// rtl/axis_labcontrol_ramp_tick.sv - free-running 0..TICK_DIV-1 counter with one-cycle tick
module axis_labcontrol_ramp_tick
  import axis_labcontrol_pkg::*;
#(
  parameter int TICK_DIV = LC_TICK_DIV
) (
  input  logic i_clk,
  input  logic i_rst_n,
  output logic o_tick
);

  localparam int CW = lc_cnt_width(TICK_DIV);
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] r_count;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= '0;
    end else if (r_count == LAST) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + 1'b1;
    end
  end

  // With TICK_DIV=1 the counter sits at 0 and the tick is permanently high.
  assign o_tick = (r_count == LAST);

endmodule

// File: rtl/axis_labcontrol_ramp.sv
// rtl/axis_labcontrol_ramp.sv - rate-limited setpoint ramp between two streams; optional tlast via AXIS_LC_RAMP_TLAST_EN
module axis_labcontrol_ramp
  import axis_labcontrol_pkg::*;
#(
  parameter int DATA_WIDTH = LC_DATA_WIDTH,
  parameter int STEP       = 1,
  parameter int TICK_DIV   = LC_TICK_DIV
) (
  input  logic                  s_axis_aclk,
  input  logic                  s_axis_aresetn,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
`ifdef AXIS_LC_RAMP_TLAST_EN
  output logic                  m_axis_tlast,
`endif
  output logic                  busy
);

  localparam logic signed [DATA_WIDTH:0]   STEP_W = (DATA_WIDTH + 1)'(STEP);
  localparam logic signed [DATA_WIDTH-1:0] STEP_D = DATA_WIDTH'(STEP);

  ramp_state_t                   r_state;
  logic signed [DATA_WIDTH-1:0]  r_current;
  logic signed [DATA_WIDTH-1:0]  r_target;
  logic                          r_tvalid;

  logic                          w_tick;
  logic                          w_accept;
  logic                          w_pending;
  logic                          w_update;
  logic                          w_reach;
  logic signed [DATA_WIDTH:0]    w_diff;
  logic signed [DATA_WIDTH-1:0]  w_next;
  logic signed [DATA_WIDTH-1:0]  w_target_nx;
  logic signed [DATA_WIDTH-1:0]  w_current_nx;

  axis_labcontrol_ramp_tick #(
    .TICK_DIV (TICK_DIV)
  ) u_tick (
    .i_clk   (s_axis_aclk),
    .i_rst_n (s_axis_aresetn),
    .o_tick  (w_tick)
  );

  assign s_axis_tready = s_axis_aresetn;
  assign w_accept      = s_axis_tvalid & s_axis_tready;
  assign w_pending     = r_tvalid & ~m_axis_tready;
  assign w_update      = (r_state == ST_RAMP) & w_tick & ~w_pending;

  // One extra bit keeps full-scale swings (e.g. +max to -min) from wrapping.
  assign w_diff  = $signed({r_target[DATA_WIDTH-1], r_target})
                 - $signed({r_current[DATA_WIDTH-1], r_current});
  assign w_reach = (w_diff <= STEP_W) && (w_diff >= -STEP_W);

  always_comb begin
    w_next = r_target;
    if (!w_reach) begin
      w_next = w_diff[DATA_WIDTH] ? (r_current - STEP_D) : (r_current + STEP_D);
    end
  end

  assign w_target_nx  = w_accept ? $signed(s_axis_tdata) : r_target;
  assign w_current_nx = w_update ? w_next : r_current;

  always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
    if (!s_axis_aresetn) begin
      r_state   <= ST_IDLE;
      r_current <= '0;
      r_target  <= '0;
      r_tvalid  <= 1'b0;
    end else begin
      if (w_accept) begin
        r_target <= s_axis_tdata;
      end
      if (w_update) begin
        r_current <= w_next;
      end
      r_state <= (w_current_nx != w_target_nx) ? ST_RAMP : ST_IDLE;
      if (w_update) begin
        r_tvalid <= 1'b1;
      end else if (m_axis_tready) begin
        r_tvalid <= 1'b0;
      end
    end
  end

`ifdef AXIS_LC_RAMP_TLAST_EN
  logic r_tlast;

  // Compared against the target in force at issue, not one accepted alongside.
  always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
    if (!s_axis_aresetn) begin
      r_tlast <= 1'b0;
    end else if (w_update) begin
      r_tlast <= (w_next == r_target);
    end
  end

  assign m_axis_tlast = r_tlast;
`endif

  assign m_axis_tdata  = r_current;
  assign m_axis_tvalid = r_tvalid;
  assign busy          = (r_state == ST_RAMP) | r_tvalid;

endmodule

// File: tb/tb_axis_labcontrol_ramp.sv
// tb/tb_axis_labcontrol_ramp.sv - directed table-driven bench for axis_labcontrol_ramp
module tb_axis_labcontrol_ramp;

  logic        clk;
  logic        rst_n;
  logic [15:0] a_s_tdata, b_s_tdata;
  logic        a_s_tvalid, b_s_tvalid;
  logic        a_s_tready, b_s_tready;
  logic [15:0] a_m_tdata, b_m_tdata;
  logic        a_m_tvalid, b_m_tvalid;
  logic        a_m_tready, b_m_tready;
  logic        a_busy, b_busy;
`ifdef AXIS_LC_RAMP_TLAST_EN
  logic        a_m_tlast, b_m_tlast;
`endif

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;
  int exp_tgt_a = 0;

  typedef int beats_t[8];

  typedef struct {
    bit sel;
    int target;
    int n;
    int b0, b1, b2, b3, b4, b5;
  } vec_t;

  axis_labcontrol_ramp #(.DATA_WIDTH(16), .STEP(10), .TICK_DIV(4)) dut_a (
    .s_axis_aclk    (clk),
    .s_axis_aresetn (rst_n),
    .s_axis_tdata   (a_s_tdata),
    .s_axis_tvalid  (a_s_tvalid),
    .s_axis_tready  (a_s_tready),
    .m_axis_tdata   (a_m_tdata),
    .m_axis_tvalid  (a_m_tvalid),
    .m_axis_tready  (a_m_tready),
`ifdef AXIS_LC_RAMP_TLAST_EN
    .m_axis_tlast   (a_m_tlast),
`endif
    .busy           (a_busy)
  );

  axis_labcontrol_ramp #(.DATA_WIDTH(16), .STEP(16384), .TICK_DIV(4)) dut_b (
    .s_axis_aclk    (clk),
    .s_axis_aresetn (rst_n),
    .s_axis_tdata   (b_s_tdata),
    .s_axis_tvalid  (b_s_tvalid),
    .s_axis_tready  (b_s_tready),
    .m_axis_tdata   (b_m_tdata),
    .m_axis_tvalid  (b_m_tvalid),
    .m_axis_tready  (b_m_tready),
`ifdef AXIS_LC_RAMP_TLAST_EN
    .m_axis_tlast   (b_m_tlast),
`endif
    .busy           (b_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int mdata(input bit sel);
    return sel ? int'($signed(b_m_tdata)) : int'($signed(a_m_tdata));
  endfunction

  function automatic bit mvalid(input bit sel);
    return sel ? b_m_tvalid : a_m_tvalid;
  endfunction

  function automatic bit mbusy(input bit sel);
    return sel ? b_busy : a_busy;
  endfunction

  // Called on a negedge; returns on the following negedge.
  task automatic send_target(input bit sel, input int t);
    if (sel) begin
      b_s_tdata = 16'(t); b_s_tvalid = 1'b1;
    end else begin
      a_s_tdata = 16'(t); a_s_tvalid = 1'b1; exp_tgt_a = t;
    end
    @(negedge clk);
    a_s_tvalid = 1'b0;
    b_s_tvalid = 1'b0;
  endtask

  task automatic collect(input bit sel, input int n, input beats_t e,
                         input bit check_idle, input string name);
    int got = 0;
    int last_cyc = -1;
    int waited = 0;
    int budget = (n == 0) ? 12 : n * 4 + 10;
    while (waited < budget && (n == 0 || got < n)) begin
      @(negedge clk);
      waited++;
      if (mvalid(sel)) begin
        if (got < n) begin
          chk($sformatf("%s beat%0d", name, got), mdata(sel), e[got]);
          chk($sformatf("%s busy%0d", name, got), int'(mbusy(sel)), 1);
          if (last_cyc >= 0) chk($sformatf("%s gap%0d", name, got), cyc - last_cyc, 4);
`ifdef AXIS_LC_RAMP_TLAST_EN
          if (!sel) chk($sformatf("%s tlast%0d", name, got), int'(a_m_tlast), int'(e[got] == exp_tgt_a));
`endif
        end else begin
          chk($sformatf("%s unexpected_beat", name), mdata(sel), 99999);
        end
        last_cyc = cyc;
        got++;
      end
    end
    if (n > 0) chk($sformatf("%s beat_count", name), got, n);
    if (check_idle) begin
      @(negedge clk);
      chk($sformatf("%s busy_after", name), int'(mbusy(sel)), 0);
      chk($sformatf("%s tvalid_after", name), int'(mvalid(sel)), 0);
    end
  endtask

  initial begin
    vec_t   vecs[6];
    beats_t e;
    int     bad;
    int     held;

    vecs[0] = '{0,     25, 3,     10,     20,     25,      0, 0, 0};
    vecs[1] = '{0,     -5, 3,     15,      5,     -5,      0, 0, 0};
    vecs[2] = '{0,     -5, 0,      0,      0,      0,      0, 0, 0};
    vecs[3] = '{0,    -12, 1,    -12,      0,      0,      0, 0, 0};
    vecs[4] = '{1,  32767, 2,  16384,  32767,      0,      0, 0, 0};
    vecs[5] = '{1, -32768, 4,  16383,     -1, -16385, -32768, 0, 0};

    rst_n = 1'b0;
    a_s_tdata = '0; b_s_tdata = '0;
    a_s_tvalid = 1'b0; b_s_tvalid = 1'b0;
    a_m_tready = 1'b1; b_m_tready = 1'b1;

    repeat (3) @(negedge clk);
    chk("rst tready", int'(a_s_tready), 0);
    chk("rst tvalid", int'(a_m_tvalid), 0);
    chk("rst tdata", mdata(0), 0);
    chk("rst busy", int'(a_busy), 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst tready", int'(a_s_tready), 1);

    for (int i = 0; i < 6; i++) begin
      e = '{vecs[i].b0, vecs[i].b1, vecs[i].b2, vecs[i].b3, vecs[i].b4, vecs[i].b5, 0, 0};
      send_target(vecs[i].sel, vecs[i].target);
      collect(vecs[i].sel, vecs[i].n, e, 1'b1, $sformatf("vec%0d", i));
    end

    // Backpressure: first beat held through 10 ticks, then ramp resumes.
    a_m_tready = 1'b0;
    send_target(0, 38);
    held = 0;
    for (int k = 0; k < 12 && !a_m_tvalid; k++) @(negedge clk);
    chk("hold first_valid", int'(a_m_tvalid), 1);
    chk("hold first_data", mdata(0), -2);
    bad = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (!a_m_tvalid || mdata(0) != -2) bad++;
      held++;
    end
    chk("hold stable", bad, 0);
    a_m_tready = 1'b1;
    e = '{8, 18, 28, 38, 0, 0, 0, 0};
    collect(0, 4, e, 1'b1, "resume");

    // Asynchronous reset in the middle of a ramp.
    send_target(0, 100);
    e = '{48, 0, 0, 0, 0, 0, 0, 0};
    collect(0, 1, e, 1'b0, "pre_rst");
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst tvalid", int'(a_m_tvalid), 0);
    chk("midrst tdata", mdata(0), 0);
    chk("midrst busy", int'(a_busy), 0);
    chk("midrst tready", int'(a_s_tready), 0);
    @(negedge clk);
    rst_n = 1'b1;
    exp_tgt_a = 0;
    bad = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (a_m_tvalid || a_busy) bad++;
    end
    chk("post_midrst quiet", bad, 0);

    // Direction reversal at ramp value 30.
    send_target(0, 100);
    e = '{10, 20, 30, 0, 0, 0, 0, 0};
    collect(0, 3, e, 1'b0, "rev_up");
    send_target(0, -20);
    e = '{20, 10, 0, -10, -20, 0, 0, 0};
    collect(0, 5, e, 1'b1, "rev_down");

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
